serial_bit_feeder: RTL and testbench

Parallel-to-serial front end for the serial pattern-detector FSMs: it accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a serial `x` line, with `x_valid` qualifying each bit. A one-word pending buffer allows back-to-back words to stream with no bit gaps. A `hold` input stalls the stream, and a wrapping counter reports completed words.

---
 rtl/serial_bit_feeder_if.sv | 23 ++
 rtl/serial_bit_feeder.sv | 105 ++++++++++
 tb/tb_serial_bit_feeder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/serial_bit_feeder_if.sv
// Word-in / bit-out bundle between a word source and serial_bit_feeder.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             hold;
  logic             x;
  logic             x_valid;
  logic             frame_start;
  logic [15:0]      words_sent;

  modport master (
    output din, din_valid, hold,
    input  din_ready, x, x_valid, frame_start, words_sent
  );

  modport slave (
    input  din, din_valid, hold,
    output din_ready, x, x_valid, frame_start, words_sent
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: WIDTH-bit words in over valid/ready, one bit per
// clock out on x, with a one-word pending buffer so words stream gap-free.
//
// state | meaning
// IDLE  | no word in flight, x_valid low
// SHIFT | shreg holds a word, bit bitcnt is on x
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           rst,
  serial_bit_feeder_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [15:0]      words_sent_q, words_sent_d;

  logic             accept;
  logic             last_edge;
  logic [WIDTH-1:0] shifted;

  assign accept    = bus.din_valid && !pend_full_q;
  assign last_edge = (state_q == SHIFT) && !bus.hold && (bitcnt_q == LAST);
  assign shifted   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      words_sent_q <= words_sent_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    words_sent_d = words_sent_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d  = bus.din;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // At the last-bit edge an accepted word bypasses pend straight into shreg.
        if (accept && !last_edge) begin
          pend_d      = bus.din;
          pend_full_d = 1'b1;
        end
        if (!bus.hold) begin
          if (bitcnt_q != LAST) begin
            shreg_d  = shifted;
            bitcnt_d = bitcnt_q + CW'(1);
          end else begin
            words_sent_d = words_sent_q + 16'd1;
            bitcnt_d     = '0;
            if (pend_full_q) begin
              shreg_d     = pend_q;
              pend_full_d = 1'b0;
            end else if (accept) begin
              shreg_d = bus.din;
            end else begin
              shreg_d = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.din_ready   = !pend_full_q;
    bus.x           = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    bus.x_valid     = (state_q == SHIFT);
    bus.frame_start = (state_q == SHIFT) && (bitcnt_q == '0);
    bus.words_sent  = words_sent_q;
  end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: reset, MSB/LSB order, streaming,
// hold, counter wrap and asynchronous reset mid-stream.
module tb_serial_bit_feeder;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  serial_bit_feeder_if #(.WIDTH(8)) if0 ();
  serial_bit_feeder_if #(.WIDTH(8)) if1 ();

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] exp24;
    logic [10:0] hexp;
    logic [7:0]  lexp;
    logic [2:0]  hist;
    int          first_hit;

    tests = 0;
    fails = 0;
    rst = 1'b0;
    if0.din = '0; if0.din_valid = 1'b0; if0.hold = 1'b0;
    if1.din = '0; if1.din_valid = 1'b0; if1.hold = 1'b0;

    #12;
    chk("rst_x_valid", 32'(if0.x_valid), 32'd0);
    chk("rst_x", 32'(if0.x), 32'd0);
    chk("rst_frame_start", 32'(if0.frame_start), 32'd0);
    chk("rst_din_ready", 32'(if0.din_ready), 32'd1);
    chk("rst_words_sent", 32'(if0.words_sent), 32'd0);
    rst = 1'b1;
    step();

    // single word A5, MSB first
    if0.din = 8'hA5; if0.din_valid = 1'b1;
    step();
    if0.din_valid = 1'b0;
    lexp = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("single_x", 32'(if0.x), 32'(lexp[7-i]));
      chk("single_x_valid", 32'(if0.x_valid), 32'd1);
      chk("single_frame_start", 32'(if0.frame_start), (i == 0) ? 32'd1 : 32'd0);
      step();
    end
    chk("single_x_valid_after", 32'(if0.x_valid), 32'd0);
    chk("single_words_sent", 32'(if0.words_sent), 32'd1);

    // back-to-back 50, A0, FF with din_valid held high
    if0.din = 8'h50; if0.din_valid = 1'b1;
    step();
    exp24 = 24'h50A0FF;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) if0.din = 8'hA0;
      if (i == 1) begin
        chk("b2b_ready_pend_full", 32'(if0.din_ready), 32'd0);
        if0.din = 8'hFF;
      end
      if (i == 8) chk("b2b_ready_freed", 32'(if0.din_ready), 32'd1);
      if (i == 9) begin
        if0.din_valid = 1'b0;
        chk("b2b_ready_full_again", 32'(if0.din_ready), 32'd0);
      end
      chk("b2b_x_valid", 32'(if0.x_valid), 32'd1);
      chk("b2b_x", 32'(if0.x), 32'(exp24[23-i]));
      chk("b2b_frame_start", 32'(if0.frame_start), (i % 8 == 0) ? 32'd1 : 32'd0);
      step();
    end
    chk("b2b_x_valid_after", 32'(if0.x_valid), 32'd0);
    chk("b2b_words_sent", 32'(if0.words_sent), 32'd4);

    // C3 with hold raised for 3 edges after the 4th bit
    if0.din = 8'hC3; if0.din_valid = 1'b1;
    step();
    if0.din_valid = 1'b0;
    hexp = 11'b11000000011;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) if0.hold = 1'b1;
      if (i == 6) if0.hold = 1'b0;
      if (i == 5) chk("hold_words_frozen", 32'(if0.words_sent), 32'd4);
      chk("hold_x", 32'(if0.x), 32'(hexp[10-i]));
      chk("hold_x_valid", 32'(if0.x_valid), 32'd1);
      step();
    end
    chk("hold_x_valid_after", 32'(if0.x_valid), 32'd0);
    chk("hold_words_sent", 32'(if0.words_sent), 32'd5);

    // LSB-first 05 feeding a "101" detector model
    if1.din = 8'h05; if1.din_valid = 1'b1;
    step();
    if1.din_valid = 1'b0;
    lexp = 8'h05;
    hist = 3'b000;
    first_hit = -1;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_x", 32'(if1.x), 32'(lexp[i]));
      hist = {hist[1:0], if1.x};
      if (i >= 2 && hist == 3'b101 && first_hit < 0) first_hit = i;
      step();
    end
    chk("lsb_detect_bit", 32'(first_hit), 32'd2);
    chk("lsb_words_sent", 32'(if1.words_sent), 32'd1);

    // asynchronous reset mid-stream with a pending word
    if0.din = 8'h5A; if0.din_valid = 1'b1;
    step();
    if0.din = 8'h3C;
    step();
    chk("mid_pend_full", 32'(if0.din_ready), 32'd0);
    if0.din_valid = 1'b0;
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_x_valid", 32'(if0.x_valid), 32'd0);
    chk("mid_rst_x", 32'(if0.x), 32'd0);
    chk("mid_rst_frame_start", 32'(if0.frame_start), 32'd0);
    chk("mid_rst_words_sent", 32'(if0.words_sent), 32'd0);
    chk("mid_rst_din_ready", 32'(if0.din_ready), 32'd1);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_pend_discarded", 32'(if0.x_valid), 32'd0);
    end

    // words_sent wrap from 65535
    force u0.words_sent_q = 16'hFFFF;
    #1;
    release u0.words_sent_q;
    chk("wrap_preload", 32'(if0.words_sent), 32'hFFFF);
    if0.din = 8'h81; if0.din_valid = 1'b1;
    step();
    if0.din_valid = 1'b0;
    repeat (7) step();
    chk("wrap_before_last", 32'(if0.words_sent), 32'hFFFF);
    step();
    chk("wrap_words_sent", 32'(if0.words_sent), 32'd0);
    chk("wrap_x_valid_after", 32'(if0.x_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
